// File: rtl/hazard_ctrl.sv
// Stall/forward controller for a 5-stage MIPS pipeline: shadow scoreboard of E/M/W
// destinations with Tnew countdown, Tuse-based stalls, forwarding selects, and mult/div sequencing.
// Optional build macro STALL_CNT_EN adds a saturating 32-bit stall-cycle counter output.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] wreg_d,
  input  logic       regwrite_d,
  input  logic [1:0] tnew_d,
  input  logic       md_use_d,
  input  logic       md_start_d,
  input  logic       md_kind_d,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       md_busy
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic             e_valid, m_valid, w_valid;
  logic [4:0]       e_wreg, m_wreg, w_wreg;
  logic [1:0]       e_tnew, m_tnew, w_tnew;
  logic [4:0]       e_rs, e_rt;
  logic             e_md_start, e_md_kind;
  logic [CNT_W-1:0] cnt;

  logic d_valid;
  logic hazard_rs, hazard_rt, hazard_md;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic reg_hazard(
    input logic [4:0] s, input logic [1:0] tuse,
    input logic ev, input logic [4:0] ew, input logic [1:0] et,
    input logic mv, input logic [4:0] mw, input logic [1:0] mt
  );
    if (s == 5'd0 || tuse == 2'd3) return 1'b0;
    return (ev && ew == s && et > tuse) || (mv && mw == s && mt > tuse);
  endfunction

  // Youngest match decides; a not-yet-ready E match blocks an older ready M result.
  function automatic logic [1:0] sel_d(
    input logic [4:0] s,
    input logic ev, input logic [4:0] ew, input logic [1:0] et,
    input logic mv, input logic [4:0] mw, input logic [1:0] mt
  );
    if (s == 5'd0) return 2'd0;
    if (ev && ew == s) return (et == 2'd0) ? 2'd2 : 2'd0;
    if (mv && mw == s && mt == 2'd0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [1:0] sel_e(
    input logic [4:0] s,
    input logic mv, input logic [4:0] mw, input logic [1:0] mt,
    input logic wv, input logic [4:0] ww
  );
    if (s == 5'd0) return 2'd0;
    if (mv && mw == s && mt == 2'd0) return 2'd1;
    if (wv && ww == s) return 2'd2;
    return 2'd0;
  endfunction

  assign d_valid = regwrite_d && (wreg_d != 5'd0);
  assign md_busy = (cnt != '0);

  always_comb begin
    hazard_rs = reg_hazard(rs_d, tuse_rs_d, e_valid, e_wreg, e_tnew, m_valid, m_wreg, m_tnew);
    hazard_rt = reg_hazard(rt_d, tuse_rt_d, e_valid, e_wreg, e_tnew, m_valid, m_wreg, m_tnew);
    hazard_md = md_use_d && (e_md_start || md_busy);
    stall     = hazard_rs || hazard_rt || hazard_md;
  end

  always_comb begin
    fwd_rs_d = sel_d(rs_d, e_valid, e_wreg, e_tnew, m_valid, m_wreg, m_tnew);
    fwd_rt_d = sel_d(rt_d, e_valid, e_wreg, e_tnew, m_valid, m_wreg, m_tnew);
    fwd_rs_e = sel_e(e_rs, m_valid, m_wreg, m_tnew, w_valid, w_wreg);
    fwd_rt_e = sel_e(e_rt, m_valid, m_wreg, m_tnew, w_valid, w_wreg);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid <= 1'b0;
      w_wreg  <= '0;
      w_tnew  <= '0;
      m_valid <= 1'b0;
      m_wreg  <= '0;
      m_tnew  <= '0;
    end else begin
      w_valid <= m_valid;
      w_wreg  <= m_wreg;
      w_tnew  <= tnew_dec(m_tnew);
      m_valid <= e_valid;
      m_wreg  <= e_wreg;
      m_tnew  <= tnew_dec(e_tnew);
    end
  end

  // A stalled D instruction stays in D; E receives a bubble instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid    <= 1'b0;
      e_wreg     <= '0;
      e_tnew     <= '0;
      e_rs       <= '0;
      e_rt       <= '0;
      e_md_start <= 1'b0;
      e_md_kind  <= 1'b0;
    end else if (stall) begin
      e_valid    <= 1'b0;
      e_wreg     <= '0;
      e_tnew     <= '0;
      e_rs       <= '0;
      e_rt       <= '0;
      e_md_start <= 1'b0;
      e_md_kind  <= 1'b0;
    end else begin
      e_valid    <= d_valid;
      e_wreg     <= wreg_d;
      e_tnew     <= tnew_d;
      e_rs       <= rs_d;
      e_rt       <= rt_d;
      e_md_start <= md_start_d;
      e_md_kind  <= md_kind_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (e_md_start) begin
      cnt <= e_md_kind ? DIV_LOAD : MULT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected outputs are queued as each D instruction is
// driven and popped/compared at the following negative clock edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, wreg_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic       regwrite_d, md_use_d, md_start_d, md_kind_d;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
  int          exp_sc = 0;
`endif

  typedef struct {
    logic       stall;
    logic [1:0] frsd, frtd, frse, frte;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .wreg_d(wreg_d), .regwrite_d(regwrite_d), .tnew_d(tnew_d),
    .md_use_d(md_use_d), .md_start_d(md_start_d), .md_kind_d(md_kind_d),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .md_busy(md_busy)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] trs, input logic [1:0] trt,
                       input logic [4:0] wr, input logic rw, input logic [1:0] tn,
                       input logic mu, input logic ms, input logic mk);
    rs_d = rs; rt_d = rt; tuse_rs_d = trs; tuse_rt_d = trt;
    wreg_d = wr; regwrite_d = rw; tnew_d = tn;
    md_use_d = mu; md_start_d = ms; md_kind_d = mk;
  endtask

  task automatic nop();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic st, input logic [1:0] frsd, input logic [1:0] frtd,
                      input logic [1:0] frse, input logic [1:0] frte, input logic busy);
    exp_t e;
    e.stall = st; e.frsd = frsd; e.frtd = frtd; e.frse = frse; e.frte = frte; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".stall"},    {31'd0, stall},    {31'd0, e.stall});
      cmp({tag, ".fwd_rs_d"}, {30'd0, fwd_rs_d}, {30'd0, e.frsd});
      cmp({tag, ".fwd_rt_d"}, {30'd0, fwd_rt_d}, {30'd0, e.frtd});
      cmp({tag, ".fwd_rs_e"}, {30'd0, fwd_rs_e}, {30'd0, e.frse});
      cmp({tag, ".fwd_rt_e"}, {30'd0, fwd_rt_e}, {30'd0, e.frte});
      cmp({tag, ".md_busy"},  {31'd0, md_busy},  {31'd0, e.busy});
`ifdef STALL_CNT_EN
      cmp({tag, ".stall_cnt"}, stall_cnt, 32'(exp_sc));
      if (e.stall) exp_sc++;
`endif
    end
  endtask

  task automatic cyc(input string tag);
    @(negedge clk);
    check_now(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) begin
      nop();
      push(0, 0, 0, 0, 0, 0);
      cyc("flush");
    end
  endtask

  initial begin
    reset = 1'b1;
    nop();
    push(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_now("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // lw $1 (tnew 2) then addu $2,$1,$3
    set_d(5'd4, 5'd0, 2'd1, 2'd3, 5'd1, 1'b1, 2'd2, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0); cyc("lw_d");
    set_d(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 1'b1, 2'd1, 0, 0, 0);
    push(1, 0, 0, 0, 0, 0); cyc("lw_use_stall");
    push(0, 0, 0, 0, 0, 0); cyc("lw_use_go");
    nop();
    push(0, 0, 0, 2, 0, 0); cyc("lw_use_fwd_w");
    flush(3);

    // addu $1 (tnew 1) then beq $1,$0
    set_d(5'd3, 5'd4, 2'd1, 2'd1, 5'd1, 1'b1, 2'd1, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0); cyc("addu_d");
    set_d(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 0, 0, 0);
    push(1, 0, 0, 0, 0, 0); cyc("beq_stall");
    push(0, 1, 0, 0, 0, 0); cyc("beq_fwd_m");
    nop();
    push(0, 0, 0, 2, 0, 0); cyc("beq_e_fwd_w");
    flush(3);

    // jal then jr $31
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 1'b1, 2'd0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0); cyc("jal_d");
    set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0, 0, 0, 0);
    push(0, 2, 0, 0, 0, 0); cyc("jr_fwd_e");
    nop();
    push(0, 0, 0, 1, 0, 0); cyc("jr_e_fwd_m");
    flush(3);

    // two writers of $5: youngest unready blocks D forward, M beats W in E
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 1'b1, 2'd1, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0); cyc("w5_a");
    push(0, 0, 0, 0, 0, 0); cyc("w5_b");
    set_d(5'd0, 5'd5, 2'd3, 2'd2, 5'd0, 1'b0, 2'd0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0); cyc("sw5_youngest");
    nop();
    push(0, 0, 0, 0, 1, 0); cyc("sw5_e_m_over_w");
    flush(3);

    // lw $7 then rt uses in M then D; W never forwarded into D
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 1'b1, 2'd2, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0); cyc("lw7_d");
    set_d(5'd0, 5'd7, 2'd3, 2'd2, 5'd0, 1'b0, 2'd0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0); cyc("rt7_tuse2");
    set_d(5'd0, 5'd7, 2'd3, 2'd0, 5'd0, 1'b0, 2'd0, 0, 0, 0);
    push(1, 0, 0, 0, 0, 0); cyc("rt7_tuse0_stall");
    push(0, 0, 0, 0, 0, 0); cyc("rt7_no_w_to_d");
    flush(3);

    // write to $0 then use of $0
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b1, 2'd0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0); cyc("w0_d");
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0); cyc("use0");
    flush(3);

    // div then mflo
    set_d(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 1'b0, 2'd0, 1, 1, 1);
    push(0, 0, 0, 0, 0, 0); cyc("div_d");
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 1'b1, 2'd1, 1, 0, 0);
    push(1, 0, 0, 0, 0, 0); cyc("mflo_div_in_e");
    for (int i = 0; i < 10; i++) begin
      push(1, 0, 0, 0, 0, 1); cyc("mflo_div_busy");
    end
    push(0, 0, 0, 0, 0, 0); cyc("mflo_div_done");
    flush(3);

    // mult then mfhi
    set_d(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 1'b0, 2'd0, 1, 1, 0);
    push(0, 0, 0, 0, 0, 0); cyc("mult_d");
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd11, 1'b1, 2'd1, 1, 0, 0);
    push(1, 0, 0, 0, 0, 0); cyc("mfhi_mult_in_e");
    for (int i = 0; i < 5; i++) begin
      push(1, 0, 0, 0, 0, 1); cyc("mfhi_mult_busy");
    end
    push(0, 0, 0, 0, 0, 0); cyc("mfhi_mult_done");
    flush(3);

    // reset while busy with a load in M
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 1, 1, 1);
    push(0, 0, 0, 0, 0, 0); cyc("rst_div_d");
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 1'b1, 2'd2, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0); cyc("rst_lw_d");
    set_d(5'd1, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1, 0, 0);
    push(1, 0, 0, 0, 0, 1); cyc("rst_pre_e");
    push(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    check_now("rst_pre_m");
    #2 reset = 1'b1;
    #1;
`ifdef STALL_CNT_EN
    exp_sc = 0;
`endif
    push(0, 0, 0, 0, 0, 0);
    check_now("rst_mid_op");
    @(posedge clk);
    #1 reset = 1'b0;
    push(0, 0, 0, 0, 0, 0); cyc("rst_after");
    flush(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall and forward controller for the 5-stage MIPS pipeline that feeds the GRF.
- Keeps a shadow scoreboard of in-flight destination registers in E, M and W, each with a Tnew countdown. Compares the scoreboard against the D-stage Tuse demand.
- Outputs: freeze/bubble control, D- and E-stage forwarding mux selects, and sequencing for the multi-cycle mult/div unit.
- W-to-D bypass is done inside the GRF, so this block never forwards W into D.

Parameters:
- MULT_CYCLES, 5, busy cycles for a mult/multu.
- DIV_CYCLES, 10, busy cycles for a div/divu.
- CNT_W, 4, width of the MD busy counter; must hold DIV_CYCLES.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears all scoreboard state
- rs_d, rt_d  in  5 each  source regs of the D instruction
- tuse_rs_d, tuse_rt_d  in  2 each  0=read in D, 1=in E, 2=in M, 3=unused
- wreg_d  in  5  destination reg of the D instruction
- regwrite_d  in  1  D instruction writes the GRF
- tnew_d  in  2  result ready in 0=E, 1=M, 2=W
- md_use_d  in  1  D instruction touches HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
- md_start_d  in  1  D instruction is mult/div
- md_kind_d  in  1  0=mult, 1=div
- stall  out  1  freeze PC and F/D; insert bubble into E
- fwd_rs_d, fwd_rt_d  out  2 each  0=GRF, 1=M result, 2=E result
- fwd_rs_e, fwd_rt_e  out  2 each  0=E pipeline reg, 1=M result, 2=W result
- md_busy  out  1  MD unit counter nonzero

Behaviour:
- State:
  - Slots E/M/W each hold {valid, wreg, tnew}; E also holds {rs_e, rt_e, md_start_e}.
  - MD counter cnt (CNT_W bits).
- Async reset:
  - All slots invalid, all fields 0, cnt=0.
  - Hence stall=0, all fwd selects=0, md_busy=0.
- Slot validity: a slot is valid only if its regwrite was set and wreg!=0. Register $0 never matches anything.
- Clock edge:
  - W<=M, with tnew saturating-decremented at 0.
  - M<=E, with tnew saturating-decremented at 0.
  - E<=D fields when stall=0. When stall=1, E<=bubble (valid=0, rs_e=rt_e=0, md_start_e=0).
- Register hazard: for each source s in {rs,rt} with s!=0 and tuse!=3:
  - stall if E valid, wreg_e==s and tnew_e>tuse.
  - stall if M valid, wreg_m==s and tnew_m>tuse.
- MD hazard: stall if md_use_d and (md_start_e or cnt!=0).
- stall is the OR of all hazard terms, combinational, with the same-cycle response.
- D forwarding (per source):
  - The youngest matching slot wins.
  - E match with tnew_e==0 gives 2.
  - Otherwise M match (no E match) with tnew_m==0 gives 1.
  - Otherwise 0, including when the youngest match is not yet ready.
- E forwarding (per rs_e/rt_e, ignored if 0):
  - M match with tnew_m==0 gives 1.
  - Otherwise W match gives 2.
  - Otherwise 0.
  - M has priority over W.
- MD sequencing:
  - Edge with md_start_e=1: cnt<=MULT_CYCLES or DIV_CYCLES per the latched kind.
  - Otherwise, if cnt!=0: cnt<=cnt-1.
  - md_busy=(cnt!=0).
  - A new start cannot arrive while busy because it is stalled.
- Reset mid-operation: cnt and all slots clear immediately (asynchronously), with no pending stall.
- Simultaneous hazards: stall is asserted once; forwarding selects are still driven but ignored by the datapath.

Optional Feature:
- STALL_CNT_EN defined:
  - Adds output stall_cnt (32-bit) counting cycles with stall=1.
  - Saturates at 0xFFFFFFFF; async-cleared by reset.
- STALL_CNT_EN undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- lw $1 (tnew 2) then addu $2,$1,$3 (tuse_rs 1):
  - stall=1 for exactly 1 cycle.
  - Next cycle fwd_rs_e=2 from W.
- addu $1 (tnew 1) then beq $1,$0 (tuse 0):
  - stall=1 for 1 cycle.
  - Then fwd_rs_d=1 (M).
- jal (wreg 31, tnew 0) then jr $31 (tuse 0): stall=0, fwd_rs_d=2.
- div (md_kind 1) then mflo:
  - stall=1 on the cycle div is in E plus 10 busy cycles.
  - md_busy high exactly 10 cycles.
- Write to $0 (regwrite, wreg 0) then use of $0: stall=0 and all fwd selects 0.
- Assert reset while md_busy=1 with a load in M:
  - cnt=0, md_busy=0, stall=0 immediately.
  - stall_cnt=0 when STALL_CNT_EN is defined.
